fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined core; the next generation of the combinational EX-stage forwarding selector.
- Holds its own shift register of in-flight destination tags, one entry per stage from EX to the last stage that can source a bypass.
- Produces per-read-port bypass selects for the EX stage and a load-use stall for ID.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 5, register index width; index 0 is hard-wired zero and never forwarded.
- NUM_RP, 2, read ports per instruction (rs, rt).
- DEPTH, 3, tracked stages: entry 1 = EX, 2 = MEM, 3 = WB, ...; minimum 2.
- LOAD_LAT, 1, extra stages before load data can be bypassed; range 1..DEPTH-1.
- SEL_W, 2, fwd_sel field width; must satisfy 2^SEL_W >= DEPTH.
- CNT_W, 16, stall counter width.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- id_valid, input, 1, ID holds a real instruction.
- id_regwrite, input, 1, the ID instruction writes a register.
- id_memread, input, 1, the ID instruction is a load.
- id_rd, input, REG_AW, ID destination register.
- id_src, input, NUM_RP*REG_AW, ID source registers; port p is in bits [p*REG_AW +: REG_AW].
- id_src_used, input, NUM_RP, per-port flag: source actually read.
- flush, input, 1, kill the instructions in ID and EX.
- cnt_clr, input, 1, synchronous clear of stall_cnt.
- stall, output, 1, load-use hazard: hold PC and IF/ID, bubble into EX.
- fwd_sel, output, NUM_RP*SEL_W, per EX port: 0 = register file; k = result of stage entry k+1.
- stall_cnt, output, CNT_W, saturating count of stall cycles.

Behaviour:
- Entry fields: valid, regwrite, load, rd, plus src and src_used in entry 1 only.
- A "live writer" is an entry with valid & regwrite & rd != 0.
- Reset (reset=0, asynchronous): all entries invalid; stall_cnt=0. As a result stall=0 and fwd_sel=0 while reset is held.
- Shift on every clock edge:
  - entry[k] <= entry[k-1] for k = 2..DEPTH.
  - entry[1] <= ID fields when id_valid & ~stall & ~flush; otherwise entry[1] <= bubble (valid=0).
- Flush:
  - entry[1] becomes a bubble and the value shifting into entry[2] is also forced to a bubble (the EX instruction is killed).
  - Entries 3..DEPTH shift normally.
  - flush dominates stall.
- Stall (combinational from the ID inputs and registered entries):
  - Asserted when id_valid & ~flush and, for some port p with id_src_used[p], some entry k in 1..LOAD_LAT is a live writer with load=1 and rd == id_src[p].
  - A stall cycle inserts exactly one bubble into entry[1]. The ID instruction is re-presented by the core next cycle.
  - With LOAD_LAT=1 a load-use pair costs exactly 1 stall cycle; with LOAD_LAT=L it costs up to L cycles.
- Forwarding (combinational from registered state):
  - For port p, when entry[1] is valid and entry[1].src_used[p] is set, find the smallest k in 2..DEPTH where entry[k] is a live writer and rd == entry[1].src[p].
  - fwd_sel[p] = k-1 (nearest producer wins, e.g. MEM over WB).
  - If no match, or entry[1] is invalid or the port is unused, fwd_sel[p] = 0.
  - Source register 0 always gives 0.
  - A matching load with k < LOAD_LAT+2 cannot occur, because the stall rule prevents it.
- stall_cnt:
  - Increments by 1 on each edge where stall=1; saturates at all-ones with no wrap.
  - cnt_clr has priority over increment and resets the count to 0 on the same edge.
- Outputs carry no latency beyond the registered entries.
- Reset mid-pipeline discards all tags; the first post-reset instruction sees fwd_sel=0.

Test Plan:
- Back-to-back ALU ops: add r3 then sub r5,r3,r3 → on the sub's EX cycle fwd_sel = {1,1}, stall=0.
- Distance 2: add r3; nop; or r6,r3,r0 → port0 fwd_sel = 2. Port1 reads r0 → 0 even if an older instruction targets r0 with regwrite=1.
- Nearest wins: add r4; add r4; and r7,r4,r1 → port0 fwd_sel = 1, not 2.
- Load-use: lw r2; add r8,r2,r1 → stall=1 for exactly 1 cycle, entry[1] bubble, stall_cnt=1. Then the add reaches EX with fwd_sel port0 = 2. With LOAD_LAT=2, stall holds 2 cycles.
- Flush: lw r2 in EX, flush with a dependent instruction in ID → stall=0, both instructions killed, next EX fwd_sel = 0.
- Counter: force 2^CNT_W+3 stall cycles → stall_cnt stays at all-ones. Then cnt_clr while stall=1 → stall_cnt = 0. Assert reset mid-stream → stall_cnt = 0 and fwd_sel = 0 immediately.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Keeps a shift register of in-flight destination tags, one entry per stage
// from EX (entry 1) to the last bypass-capable stage (entry DEPTH). From these
// tags it derives the EX-stage bypass selects and the ID-stage load-use stall,
// and it counts stall cycles for performance monitoring.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_RP   = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_RP*REG_AW-1:0]  id_src,
  input  logic [NUM_RP-1:0]         id_src_used,
  input  logic                      flush,
  input  logic                      cnt_clr,
  output logic                      stall,
  output logic [NUM_RP*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Per-stage tag fields; entry 1 is EX, entry DEPTH is the oldest tracked stage.
  logic [DEPTH:1]           valid_q;
  logic [DEPTH:1]           wr_q;
  logic [DEPTH:1]           ld_q;
  logic [REG_AW-1:0]        rd_q [1:DEPTH];
  // Source operands are only needed for the instruction sitting in EX.
  logic [NUM_RP*REG_AW-1:0] src_q;
  logic [NUM_RP-1:0]        used_q;

  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic [DEPTH:1]           live;

  // An entry can source a bypass only if it really writes a non-zero register.
  always_comb begin
    live = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      live[k] = valid_q[k] & wr_q[k] & (rd_q[k] != '0);
    end
  end

  // Load-use stall: a load still too young to bypass feeds a source read in ID.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush) begin
      for (int unsigned p = 0; p < NUM_RP; p++) begin
        for (int unsigned k = 1; k <= LOAD_LAT; k++) begin
          if (id_src_used[p] && live[k] && ld_q[k] &&
              (rd_q[k] == id_src[p*REG_AW +: REG_AW])) begin
            stall = 1'b1;
          end
        end
      end
    end
  end

  // Bypass select per EX read port. Scanning oldest to youngest lets the
  // nearest producer overwrite any older match.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned p = 0; p < NUM_RP; p++) begin
      if (valid_q[1] && used_q[p]) begin
        for (int unsigned k = DEPTH; k >= 2; k--) begin
          if (live[k] && (rd_q[k] == src_q[p*REG_AW +: REG_AW])) begin
            fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k - 1);
          end
        end
      end
    end
  end

  // Stall counter next state: clear beats increment, increment saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tag pipeline advance and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      wr_q    <= '0;
      ld_q    <= '0;
      src_q   <= '0;
      used_q  <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        rd_q[k] <= '0;
      end
      cnt_q   <= '0;
    end else begin
      valid_q[1] <= id_valid & ~stall & ~flush;
      wr_q[1]    <= id_regwrite;
      ld_q[1]    <= id_memread;
      rd_q[1]    <= id_rd;
      src_q      <= id_src;
      used_q     <= id_src_used;
      // A flush also kills the instruction leaving EX, so entry 2 gets a bubble.
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        valid_q[k] <= (k == 2) ? (valid_q[1] & ~flush) : valid_q[k-1];
        wr_q[k]    <= wr_q[k-1];
        ld_q[k]    <= ld_q[k-1];
        rd_q[k]    <= rd_q[k-1];
      end
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a default instance (LOAD_LAT=1) and a
// deeper instance (DEPTH=4, LOAD_LAT=2, CNT_W=4) share the same stimulus.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_regwrite, id_memread;
  logic [4:0]  id_rd;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        flush, cnt_clr;

  logic        stall_a, stall_b;
  logic [3:0]  sel_a, sel_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_rd(id_rd), .id_src(id_src),
    .id_src_used(id_src_used), .flush(flush), .cnt_clr(cnt_clr),
    .stall(stall_a), .fwd_sel(sel_a), .stall_cnt(cnt_a)
  );

  fwd_hazard_unit #(.DEPTH(4), .LOAD_LAT(2), .SEL_W(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_rd(id_rd), .id_src(id_src),
    .id_src_used(id_src_used), .flush(flush), .cnt_clr(cnt_clr),
    .stall(stall_b), .fwd_sel(sel_b), .stall_cnt(cnt_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  task automatic expect_v(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    n_total++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic ins(input logic rw, input logic mr, input logic [4:0] rd,
                     input logic [4:0] s0, input logic [4:0] s1,
                     input logic u0, input logic u1);
    id_valid    = 1'b1;
    id_regwrite = rw;
    id_memread  = mr;
    id_rd       = rd;
    id_src      = {s1, s0};
    id_src_used = {u1, u0};
  endtask

  task automatic nop();
    id_valid    = 1'b0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
    id_rd       = '0;
    id_src      = '0;
    id_src_used = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic nop_ticks(input int unsigned n);
    nop();
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    reset   = 1'b0;
    flush   = 1'b0;
    cnt_clr = 1'b0;
    ins(1'b1, 1'b0, 5'd8, 5'd2, 5'd1, 1'b1, 1'b1);
    #3;
    expect_v("rst_stall", 0);  check(32'(stall_a));
    expect_v("rst_sel",   0);  check(32'(sel_a));
    expect_v("rst_cnt",   0);  check(32'(cnt_a));
    tick(); tick();
    reset = 1'b1;
    nop_ticks(4);

    // Back-to-back ALU dependency
    ins(1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1); tick();
    ins(1'b1, 1'b0, 5'd5, 5'd3, 5'd3, 1'b1, 1'b1); settle();
    expect_v("b2b_stall", 0);  check(32'(stall_a));
    expect_v("b2b_sel",   5);
    tick(); nop(); settle();
    check(32'(sel_a));
    nop_ticks(4);

    // Distance two, port 1 reads r0 while an older op writes r0
    ins(1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1); tick();
    ins(1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1); tick();
    ins(1'b1, 1'b0, 5'd6, 5'd3, 5'd0, 1'b1, 1'b1);
    expect_v("dist2_sel", 2);
    tick(); nop(); settle();
    check(32'(sel_a));
    nop_ticks(4);

    // Nearest producer wins
    ins(1'b1, 1'b0, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1); tick();
    ins(1'b1, 1'b0, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1); tick();
    ins(1'b1, 1'b0, 5'd7, 5'd4, 5'd1, 1'b1, 1'b1);
    expect_v("near_sel", 1);
    tick(); nop(); settle();
    check(32'(sel_a));
    nop_ticks(4);

    // Load-use with LOAD_LAT=1
    ins(1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 1'b1, 1'b0); tick();
    ins(1'b1, 1'b0, 5'd8, 5'd2, 5'd1, 1'b1, 1'b1); settle();
    expect_v("lu_stall1", 1);  check(32'(stall_a));
    expect_v("lu_cnt0",   0);  check(32'(cnt_a));
    tick(); settle();
    expect_v("lu_stall2", 0);  check(32'(stall_a));
    expect_v("lu_bubble_sel", 0); check(32'(sel_a));
    expect_v("lu_cnt1",   1);  check(32'(cnt_a));
    tick(); nop(); settle();
    expect_v("lu_fwd_sel", 2); check(32'(sel_a));
    nop_ticks(4);

    // Flush kills the load in EX and the dependent op in ID
    ins(1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 1'b1, 1'b0); tick();
    ins(1'b1, 1'b0, 5'd8, 5'd2, 5'd1, 1'b1, 1'b1);
    flush = 1'b1; settle();
    expect_v("fl_stall", 0);   check(32'(stall_a));
    tick();
    flush = 1'b0;
    ins(1'b1, 1'b0, 5'd9, 5'd2, 5'd2, 1'b1, 1'b1); settle();
    expect_v("fl_stall_next", 0); check(32'(stall_a));
    tick(); nop(); settle();
    expect_v("fl_sel", 0);     check(32'(sel_a));
    expect_v("fl_cnt", 1);     check(32'(cnt_a));
    nop_ticks(4);

    // Load-use with LOAD_LAT=2 on the deeper instance
    ins(1'b1, 1'b1, 5'd2, 5'd1, 5'd0, 1'b1, 1'b0); tick();
    ins(1'b1, 1'b0, 5'd8, 5'd2, 5'd1, 1'b1, 1'b1); settle();
    expect_v("l2_stall1", 1);  check(32'(stall_b));
    tick(); settle();
    expect_v("l2_stall2", 1);  check(32'(stall_b));
    tick(); settle();
    expect_v("l2_stall3", 0);  check(32'(stall_b));
    expect_v("l2_cnt", 4);     check(32'(cnt_b));
    tick(); nop(); settle();
    expect_v("l2_fwd_sel", 3); check(32'(sel_b));
    nop_ticks(4);

    // Saturation: self-dependent loads give two stalls every three cycles
    ins(1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0);
    repeat (45) tick();
    settle();
    expect_v("sat_cnt", 15);   check(32'(cnt_b));

    // Clear while stalled
    w = 0;
    while (stall_b !== 1'b1 && w < 10) begin
      tick(); settle();
      w++;
    end
    expect_v("clr_found_stall", 1); check(32'(stall_b));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    settle();
    expect_v("clr_cnt", 0);    check(32'(cnt_b));

    // Asynchronous reset mid-stream
    tick(); tick(); settle();
    reset = 1'b0;
    #1;
    expect_v("mrst_cnt_a", 0);   check(32'(cnt_a));
    expect_v("mrst_cnt_b", 0);   check(32'(cnt_b));
    expect_v("mrst_sel_a", 0);   check(32'(sel_a));
    expect_v("mrst_sel_b", 0);   check(32'(sel_b));
    expect_v("mrst_stall_a", 0); check(32'(stall_a));
    expect_v("mrst_stall_b", 0); check(32'(stall_b));
    tick();
    reset = 1'b1;
    ins(1'b1, 1'b0, 5'd3, 5'd2, 5'd2, 1'b1, 1'b1);
    tick(); nop(); settle();
    expect_v("post_rst_sel_a", 0); check(32'(sel_a));
    expect_v("post_rst_sel_b", 0); check(32'(sel_b));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
